// File: rtl/div_issue_ctrl.sv
// Issue/sequencing control between the execute stage and an iterative divider.
// Handles divide-by-zero and signed overflow locally and reuses the last divider result.
package div_issue_ctrl_pkg;
  typedef enum logic [2:0] {
    MD_DIV  = 3'b100,
    MD_DIVU = 3'b101,
    MD_REM  = 3'b110,
    MD_REMU = 3'b111
  } muldiv_funct3_t;
endpackage

module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  input  muldiv_funct3_t funct3,
  input  logic [31:0]    rs1,
  input  logic [31:0]    rs2,
  input  logic           flush,
  output logic           stall,
  output logic           resp_valid,
  output logic [31:0]    result,
  output logic           div_start,
  output muldiv_funct3_t div_sign,
  output logic [31:0]    div_numerator,
  output logic [31:0]    div_denominator,
  input  logic [31:0]    div_quotient,
  input  logic [31:0]    div_remainder,
  input  logic           div_done
);

  localparam int unsigned XLEN    = 32;
  localparam logic [XLEN-1:0] INT_MIN = XLEN'(32'h8000_0000);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state_q,  state_d;
  muldiv_funct3_t  sign_q,   sign_d;
  logic [XLEN-1:0] num_q,    num_d;
  logic [XLEN-1:0] den_q,    den_d;
  logic            start_q,  start_d;
  logic [XLEN-1:0] result_q, result_d;

  // Last-result cache: signedness class, operands, both divider outputs.
  logic            cv_q,    cv_d;
  logic            cs_q,    cs_d;
  logic [XLEN-1:0] ca_q,    ca_d;
  logic [XLEN-1:0] cb_q,    cb_d;
  logic [XLEN-1:0] cquo_q,  cquo_d;
  logic [XLEN-1:0] crem_q,  crem_d;

  logic req_signed, req_rem, busy_signed, busy_rem;
  logic is_div0, is_ovf, cache_hit;

  assign req_signed  = (funct3 == MD_DIV) || (funct3 == MD_REM);
  assign req_rem     = (funct3 == MD_REM) || (funct3 == MD_REMU);
  assign busy_signed = (sign_q == MD_DIV) || (sign_q == MD_REM);
  assign busy_rem    = (sign_q == MD_REM) || (sign_q == MD_REMU);

  assign is_div0   = (rs2 == '0);
  assign is_ovf    = req_signed && (rs1 == INT_MIN) && (rs2 == '1);
  assign cache_hit = CACHE_EN && cv_q && (cs_q == req_signed) &&
                     (ca_q == rs1) && (cb_q == rs2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sign_q   <= MD_DIV;
      num_q    <= '0;
      den_q    <= '0;
      start_q  <= 1'b0;
      result_q <= '0;
      cv_q     <= 1'b0;
      cs_q     <= 1'b0;
      ca_q     <= '0;
      cb_q     <= '0;
      cquo_q   <= '0;
      crem_q   <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      num_q    <= num_d;
      den_q    <= den_d;
      start_q  <= start_d;
      result_q <= result_d;
      cv_q     <= cv_d;
      cs_q     <= cs_d;
      ca_q     <= ca_d;
      cb_q     <= cb_d;
      cquo_q   <= cquo_d;
      crem_q   <= crem_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    num_d    = num_q;
    den_d    = den_q;
    start_d  = 1'b0;
    result_d = result_q;
    cv_d     = cv_q;
    cs_d     = cs_q;
    ca_d     = ca_q;
    cb_d     = cb_q;
    cquo_d   = cquo_q;
    crem_d   = crem_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          sign_d = funct3;
          num_d  = rs1;
          den_d  = rs2;
          if (is_div0) begin
            result_d = req_rem ? rs1 : '1;
            state_d  = S_RESP;
          end else if (is_ovf) begin
            result_d = req_rem ? '0 : INT_MIN;
            state_d  = S_RESP;
          end else if (cache_hit) begin
            result_d = req_rem ? crem_q : cquo_q;
            state_d  = S_RESP;
          end else begin
            start_d = 1'b1;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        // A flush coinciding with completion behaves like a finished drain.
        if (div_done) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            result_d = busy_rem ? div_remainder : div_quotient;
            cv_d     = 1'b1;
            cs_d     = busy_signed;
            ca_d     = num_q;
            cb_d     = den_q;
            cquo_d   = div_quotient;
            crem_d   = div_remainder;
            state_d  = S_RESP;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (div_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake strobes are combinational so a late flush can still kill the response.
  assign resp_valid = (state_q == S_RESP) && !flush;
  assign stall      = rst && req_valid && !resp_valid;

  assign result          = result_q;
  assign div_start       = start_q;
  assign div_sign        = sign_q;
  assign div_numerator   = num_q;
  assign div_denominator = den_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: behavioural divider, arithmetic reference
// model with an operand-level cache model, directed scenarios plus random ops.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           req_valid = 1'b0;
  muldiv_funct3_t funct3    = MD_DIV;
  logic [31:0]    rs1 = '0, rs2 = '0;
  logic           flush = 1'b0;
  logic           stall, resp_valid, div_start, div_done;
  muldiv_funct3_t div_sign;
  logic [31:0]    result, div_numerator, div_denominator, div_quotient, div_remainder;

  logic           nc_req_valid = 1'b0;
  muldiv_funct3_t nc_funct3    = MD_DIV;
  logic [31:0]    nc_rs1 = '0, nc_rs2 = '0;
  logic           nc_flush = 1'b0;
  logic           nc_stall, nc_resp_valid, nc_div_start;
  logic           nc_div_done = 1'b0;
  muldiv_funct3_t nc_div_sign;
  logic [31:0]    nc_result, nc_div_numerator, nc_div_denominator;
  logic [31:0]    nc_div_quotient = 32'd14, nc_div_remainder = 32'd2;

  int checks = 0, failures = 0;
  int start_cnt = 0, overlap = 0;
  int div_lat = 3, cnt = 0;

  bit          m_cv = 1'b0, m_s = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;

  div_issue_ctrl #(.CACHE_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .flush(flush), .stall(stall), .resp_valid(resp_valid), .result(result),
    .div_start(div_start), .div_sign(div_sign), .div_numerator(div_numerator),
    .div_denominator(div_denominator), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_done(div_done)
  );

  div_issue_ctrl #(.CACHE_EN(1'b0)) u_nc (
    .clk(clk), .rst(rst), .req_valid(nc_req_valid), .funct3(nc_funct3), .rs1(nc_rs1),
    .rs2(nc_rs2), .flush(nc_flush), .stall(nc_stall), .resp_valid(nc_resp_valid),
    .result(nc_result), .div_start(nc_div_start), .div_sign(nc_div_sign),
    .div_numerator(nc_div_numerator), .div_denominator(nc_div_denominator),
    .div_quotient(nc_div_quotient), .div_remainder(nc_div_remainder), .div_done(nc_div_done)
  );

  // RISC-V M-extension division semantics.
  function automatic logic [31:0] ref_div(input muldiv_funct3_t f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic sgn, rem;
    logic [31:0] q, r;
    sgn = (f3 == MD_DIV) || (f3 == MD_REM);
    rem = (f3 == MD_REM) || (f3 == MD_REMU);
    if (b == 32'd0) begin
      q = '1; r = a;
    end else if (sgn && a == INT_MIN && b == '1) begin
      q = INT_MIN; r = '0;
    end else if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b; r = a % b;
    end
    return rem ? r : q;
  endfunction

  function automatic bit exp_start(input muldiv_funct3_t f3, input logic [31:0] a,
                                   input logic [31:0] b);
    bit sgn;
    sgn = (f3 == MD_DIV) || (f3 == MD_REM);
    if (b == 32'd0) return 1'b0;
    if (sgn && a == INT_MIN && b == '1) return 1'b0;
    if (m_cv && m_s == sgn && m_a == a && m_b == b) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_note(input muldiv_funct3_t f3, input logic [31:0] a, input logic [31:0] b);
    m_cv = 1'b1;
    m_s  = (f3 == MD_DIV) || (f3 == MD_REM);
    m_a  = a;
    m_b  = b;
  endtask

  // Behavioural divider: fixed latency per op, garbage on the result bus when idle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_done <= 1'b0; cnt <= 0; div_quotient <= '0; div_remainder <= '0;
    end else begin
      div_done      <= 1'b0;
      div_quotient  <= $urandom;
      div_remainder <= $urandom;
      if (div_start) begin
        start_cnt <= start_cnt + 1;
        if (cnt != 0) overlap <= overlap + 1;
        cnt <= div_lat;
      end else if (cnt == 1) begin
        cnt      <= 0;
        div_done <= 1'b1;
        if (div_sign == MD_DIV || div_sign == MD_REM) begin
          div_quotient  <= ref_div(MD_DIV, div_numerator, div_denominator);
          div_remainder <= ref_div(MD_REM, div_numerator, div_denominator);
        end else begin
          div_quotient  <= ref_div(MD_DIVU, div_numerator, div_denominator);
          div_remainder <= ref_div(MD_REMU, div_numerator, div_denominator);
        end
      end else if (cnt > 1) begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic do_op(input muldiv_funct3_t f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int starts,
                       output int done_at, output int stall_bad);
    int s0;
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b0; funct3 = f3; rs1 = a; rs2 = b;
    s0 = start_cnt; lat = 0; done_at = -1; stall_bad = 0;
    #1;
    while (resp_valid !== 1'b1 && lat < 200) begin
      if (stall !== 1'b1) stall_bad++;
      if (div_done === 1'b1 && done_at < 0) done_at = lat;
      @(negedge clk); #1; lat++;
    end
    if (stall !== 1'b0) stall_bad++;
    res = result;
    starts = start_cnt - s0;
  endtask

  task automatic test_reset;
    req_valid = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    req_valid = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL reset_div_start got=%b exp=0", div_start); end
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (div_numerator !== 32'd0 || div_denominator !== 32'd0) begin
      failures++; $display("FAIL reset_operands got=%h/%h exp=0/0", div_numerator, div_denominator); end
    checks++; if (div_sign !== MD_DIV) begin failures++; $display("FAIL reset_div_sign got=%b exp=%b", div_sign, MD_DIV); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_div_basic;
    logic [31:0] res; int lat, st, dn, sb;
    div_lat = 4;
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, res, lat, st, dn, sb);
    model_note(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    checks++; if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_basic_result got=%h exp=fffffffd", res); end
    checks++; if (st != 1) begin failures++; $display("FAIL div_basic_starts got=%0d exp=1", st); end
    checks++; if (dn < 0 || lat != dn + 1) begin failures++; $display("FAIL div_basic_latency resp=%0d done=%0d exp=done+1", lat, dn); end
    checks++; if (sb != 0) begin failures++; $display("FAIL div_basic_stall bad_cycles=%0d exp=0", sb); end
    @(negedge clk); req_valid = 1'b0; #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL div_basic_one_strobe got=%b exp=0", resp_valid); end
  endtask

  task automatic test_div_by_zero;
    logic [31:0] res; int lat, st, dn, sb;
    do_op(MD_DIVU, 32'h1234_5678, 32'd0, res, lat, st, dn, sb);
    checks++; if (res !== 32'hFFFF_FFFF || lat != 1 || st != 0) begin failures++;
      $display("FAIL divu_zero got=%h lat=%0d starts=%0d exp=ffffffff lat=1 starts=0", res, lat, st); end
    do_op(MD_REMU, 32'h1234_5678, 32'd0, res, lat, st, dn, sb);
    checks++; if (res !== 32'h1234_5678 || lat != 1 || st != 0) begin failures++;
      $display("FAIL remu_zero got=%h lat=%0d starts=%0d exp=12345678 lat=1 starts=0", res, lat, st); end
    checks++; if (sb != 0) begin failures++; $display("FAIL zero_stall bad_cycles=%0d exp=0", sb); end
  endtask

  task automatic test_overflow;
    logic [31:0] res; int lat, st, dn, sb;
    do_op(MD_DIV, INT_MIN, 32'hFFFF_FFFF, res, lat, st, dn, sb);
    checks++; if (res !== INT_MIN || lat != 1 || st != 0) begin failures++;
      $display("FAIL div_ovf got=%h lat=%0d starts=%0d exp=80000000 lat=1 starts=0", res, lat, st); end
    do_op(MD_REM, INT_MIN, 32'hFFFF_FFFF, res, lat, st, dn, sb);
    checks++; if (res !== 32'd0 || lat != 1 || st != 0) begin failures++;
      $display("FAIL rem_ovf got=%h lat=%0d starts=%0d exp=0 lat=1 starts=0", res, lat, st); end
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic test_cache;
    logic [31:0] res; int lat, st, dn, sb;
    div_lat = 5;
    do_op(MD_DIVU, 32'd100, 32'd7, res, lat, st, dn, sb);
    model_note(MD_DIVU, 32'd100, 32'd7);
    checks++; if (res !== 32'd14 || st != 1) begin failures++;
      $display("FAIL cache_fill got=%0d starts=%0d exp=14 starts=1", res, st); end
    do_op(MD_REMU, 32'd100, 32'd7, res, lat, st, dn, sb);
    checks++; if (res !== 32'd2 || lat != 1 || st != 0) begin failures++;
      $display("FAIL cache_hit got=%0d lat=%0d starts=%0d exp=2 lat=1 starts=0", res, lat, st); end
    do_op(MD_REM, 32'd100, 32'd7, res, lat, st, dn, sb);
    model_note(MD_REM, 32'd100, 32'd7);
    checks++; if (res !== 32'd2 || st != 1) begin failures++;
      $display("FAIL cache_class_miss got=%0d starts=%0d exp=2 starts=1", res, st); end
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic test_cache_disabled;
    int c, starts;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      nc_req_valid = 1'b1; nc_funct3 = (k == 0) ? MD_DIVU : MD_REMU;
      nc_rs1 = 32'd100; nc_rs2 = 32'd7;
      starts = 0; c = 0; #1;
      while (nc_resp_valid !== 1'b1 && c < 30) begin
        if (nc_div_start === 1'b1) starts++;
        nc_div_done = (c == 4);
        @(negedge clk); #1; c++;
      end
      nc_div_done = 1'b0;
      checks++; if (starts != 1) begin failures++; $display("FAIL nocache_starts op=%0d got=%0d exp=1", k, starts); end
      checks++; if (nc_result !== ((k == 0) ? 32'd14 : 32'd2)) begin failures++;
        $display("FAIL nocache_result op=%0d got=%0d", k, nc_result); end
    end
    @(negedge clk); nc_req_valid = 1'b0;
  endtask

  task automatic test_flush_idle;
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; funct3 = MD_DIVU; rs1 = 32'hCAFE_0001; rs2 = 32'd0;
    @(negedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL flush_idle_accepted got=%b exp=0", resp_valid); end
    flush = 1'b0;
    @(negedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || result !== 32'hFFFF_FFFF) begin failures++;
      $display("FAIL flush_idle_later got=%b/%h exp=1/ffffffff", resp_valid, result); end
    @(negedge clk);
    funct3 = MD_REMU; rs1 = 32'd5;
    @(negedge clk);
    flush = 1'b1; #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL flush_resp_killed got=%b exp=0", resp_valid); end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0; #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL flush_resp_after got=%b exp=0", resp_valid); end
  endtask

  task automatic test_flush_busy;
    logic [31:0] res; int lat, st, dn, sb;
    int c, done_c, start_c, resp_bad, stall_bad;
    div_lat = 12;
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b0; funct3 = MD_DIV; rs1 = 32'd1000; rs2 = 32'd3;
    c = 0; #1;
    while (div_start !== 1'b1 && c < 50) begin @(negedge clk); #1; c++; end
    checks++; if (div_start !== 1'b1) begin failures++; $display("FAIL flush_first_start got=%b exp=1", div_start); end
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; div_lat = 3; funct3 = MD_DIVU; rs1 = 32'd9; rs2 = 32'd2;
    c = 0; done_c = -1; start_c = -1; resp_bad = 0; stall_bad = 0; #1;
    while (start_c < 0 && c < 60) begin
      if (resp_valid === 1'b1) resp_bad++;
      if (stall !== 1'b1) stall_bad++;
      if (div_done === 1'b1 && done_c < 0) done_c = c;
      if (div_start === 1'b1) start_c = c;
      else begin @(negedge clk); #1; c++; end
    end
    checks++; if (resp_bad != 0) begin failures++; $display("FAIL flush_no_resp got=%0d exp=0", resp_bad); end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL flush_drain_stall bad_cycles=%0d exp=0", stall_bad); end
    checks++; if (done_c < 0 || start_c != done_c + 2) begin failures++;
      $display("FAIL flush_restart start=%0d done=%0d exp=done+2", start_c, done_c); end
    c = 0; #0;
    while (resp_valid !== 1'b1 && c < 50) begin @(negedge clk); #1; c++; end
    model_note(MD_DIVU, 32'd9, 32'd2);
    checks++; if (resp_valid !== 1'b1 || result !== 32'd4) begin failures++;
      $display("FAIL flush_new_result got=%b/%0d exp=1/4", resp_valid, result); end
    do_op(MD_REMU, 32'd9, 32'd2, res, lat, st, dn, sb);
    checks++; if (res !== 32'd1 || st != 0 || lat != 1) begin failures++;
      $display("FAIL flush_cache_new got=%0d starts=%0d lat=%0d exp=1 0 1", res, st, lat); end
    do_op(MD_DIV, 32'd1000, 32'd3, res, lat, st, dn, sb);
    model_note(MD_DIV, 32'd1000, 32'd3);
    checks++; if (res !== 32'd333 || st != 1) begin failures++;
      $display("FAIL flush_cache_old got=%0d starts=%0d exp=333 1", res, st); end
    // flush landing on the completion cycle
    @(negedge clk);
    funct3 = MD_DIVU; rs1 = 32'd1000; rs2 = 32'd7;
    c = 0; #1;
    while (div_done !== 1'b1 && c < 50) begin @(negedge clk); #1; c++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0; #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL flush_done_resp got=%b exp=0", resp_valid); end
    st = exp_start(MD_DIVU, 32'd1000, 32'd7) ? 1 : 0;
    do_op(MD_DIVU, 32'd1000, 32'd7, res, lat, c, dn, sb);
    model_note(MD_DIVU, 32'd1000, 32'd7);
    checks++; if (res !== 32'd142 || c != st || lat > 50) begin failures++;
      $display("FAIL flush_done_nocache got=%0d starts=%0d lat=%0d exp=142 %0d", res, c, lat, st); end
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic test_reset_busy;
    logic [31:0] res; int lat, st, dn, sb, c;
    div_lat = 3;
    do_op(MD_DIVU, 32'd50, 32'd5, res, lat, st, dn, sb);
    model_note(MD_DIVU, 32'd50, 32'd5);
    div_lat = 20;
    @(negedge clk);
    funct3 = MD_DIVU; rs1 = 32'd77; rs2 = 32'd3;
    c = 0; #1;
    while (div_start !== 1'b1 && c < 50) begin @(negedge clk); #1; c++; end
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || resp_valid !== 1'b0 || div_start !== 1'b0) begin failures++;
      $display("FAIL rstbusy_strobes got=%b%b%b exp=000", stall, resp_valid, div_start); end
    checks++; if (result !== 32'd0 || div_numerator !== 32'd0 || div_denominator !== 32'd0) begin failures++;
      $display("FAIL rstbusy_data got=%h %h %h exp=0", result, div_numerator, div_denominator); end
    checks++; if (div_sign !== MD_DIV) begin failures++; $display("FAIL rstbusy_sign got=%b exp=%b", div_sign, MD_DIV); end
    m_cv = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    div_lat = 3;
    do_op(MD_DIVU, 32'd50, 32'd5, res, lat, st, dn, sb);
    model_note(MD_DIVU, 32'd50, 32'd5);
    checks++; if (res !== 32'd10 || st != 1) begin failures++;
      $display("FAIL rstbusy_fresh got=%0d starts=%0d exp=10 1", res, st); end
    checks++; if (dn < 0 || lat != dn + 1) begin failures++;
      $display("FAIL rstbusy_latency resp=%0d done=%0d exp=done+1", lat, dn); end
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic test_random;
    muldiv_funct3_t ops [4] = '{MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    logic [31:0] pool [8] = '{32'd0, 32'd1, 32'd2, 32'd7, 32'd100, INT_MIN, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    muldiv_funct3_t f3;
    logic [31:0] a, b, res, exp;
    int lat, st, dn, sb;
    bit es;
    a = 32'd1; b = 32'd1;
    for (int i = 0; i < 60; i++) begin
      f3 = ops[$urandom_range(0, 3)];
      if (i == 0 || $urandom_range(0, 3) != 0) begin
        a = ($urandom_range(0, 2) == 0) ? 32'($urandom) : pool[$urandom_range(0, 7)];
        b = ($urandom_range(0, 2) == 0) ? 32'($urandom) : pool[$urandom_range(0, 7)];
      end
      div_lat = $urandom_range(1, 6);
      exp = ref_div(f3, a, b);
      es  = exp_start(f3, a, b);
      do_op(f3, a, b, res, lat, st, dn, sb);
      if (es) model_note(f3, a, b);
      checks++; if (res !== exp) begin failures++;
        $display("FAIL rand_result i=%0d f3=%b a=%h b=%h got=%h exp=%h", i, f3, a, b, res, exp); end
      checks++; if (st != (es ? 1 : 0)) begin failures++;
        $display("FAIL rand_starts i=%0d got=%0d exp=%0d", i, st, es); end
      checks++; if (es ? (dn < 0 || lat != dn + 1) : (lat != 1)) begin failures++;
        $display("FAIL rand_latency i=%0d lat=%0d done=%0d div=%0d", i, lat, dn, es); end
      checks++; if (sb != 0) begin failures++; $display("FAIL rand_stall i=%0d bad_cycles=%0d exp=0", i, sb); end
    end
    @(negedge clk); req_valid = 1'b0;
    checks++; if (overlap != 0) begin failures++; $display("FAIL start_while_busy got=%0d exp=0", overlap); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    test_div_basic;
    test_div_by_zero;
    test_overflow;
    test_cache;
    test_cache_disabled;
    test_flush_idle;
    test_flush_busy;
    test_reset_busy;
    test_random;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
